debug_unit_ctrl: RTL and testbench
==================================

Name: debug_unit_ctrl

Overview:
- Debug-unit controller directly upstream of the `pipeline` top. It drives that block's debug port.
- Takes a byte stream from the UART receiver and turns it into: instruction-memory writes, PC reset, single-step or continuous clock enables, and a register/data-memory dump.
- The dump is serialised back to the UART transmitter.
- Exactly one clock domain. The UART itself is outside this block.

Parameters:
NB_REG, 32, datapath / instruction word width
NB_BYTE, 8, UART byte width
NB_ADDR, 5, register index width (32 GPRs)
N_IMEM_WORDS, 256, instruction memory depth in words
N_DMEM_WORDS, 32, data memory words included in the dump

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  NB_BYTE  received byte
i_rx_done  in  1  one-cycle pulse: i_rx_data valid
o_tx_data  out  NB_BYTE  byte to transmit
o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
i_tx_done  in  1  one-cycle pulse: transmitter finished previous byte
i_halt  in  1  pipeline retired the HALT instruction (0x0000003F)
o_dunit_clk_en  out  1  pipeline clock enable
o_dunit_reset_pc  out  1  PC reset pulse
o_dunit_w_mem  out  1  instruction memory write strobe
o_dunit_addr  out  NB_REG  IMEM write byte address / dump select
o_dunit_data_if  out  NB_REG  instruction word to write
i_dunit_reg  in  NB_REG  register file read data at o_dunit_addr[NB_ADDR-1:0]
i_dunit_mem_data  in  NB_REG  data memory read data at o_dunit_addr

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; state IDLE; word pointer 0; halted flag 0.
  - Reset mid-operation aborts any load, run or dump immediately. No partial byte is emitted after reset.
- Commands, accepted only in IDLE:
  - 'L' 0x4C: load program.
  - 'R' 0x52: reset PC.
  - 'S' 0x53: single step.
  - 'C' 0x43: continuous run.
  - Any other byte is ignored.
  - Bytes arriving in RUN, STEP or DUMP states are dropped.
- States: IDLE, LOAD_BYTE, LOAD_WRITE, RPC, STEP, RUN, DUMP_SET, DUMP_CAP, DUMP_SEND, DUMP_WAIT.
- LOAD:
  - Clears the halted flag and the word pointer.
  - Collects 4 bytes, MSB first, into a word register.
  - In LOAD_WRITE, o_dunit_w_mem=1 for exactly one cycle, with o_dunit_addr = 4*ptr and o_dunit_data_if = word. ptr then increments.
  - After writing the word 0x0000003F, or after writing word N_IMEM_WORDS-1 (no wrap), go to IDLE.
  - Between writes o_dunit_w_mem=0; o_dunit_addr and o_dunit_data_if hold their last value.
- RPC: o_dunit_reset_pc=1 for exactly one cycle; halted flag cleared; then IDLE.
- STEP:
  - If halted, go straight to DUMP.
  - Otherwise o_dunit_clk_en=1 for exactly one cycle, then DUMP.
  - If i_halt=1 in that cycle, the halted flag is set.
- RUN:
  - If halted, go straight to DUMP.
  - Otherwise o_dunit_clk_en=1 every cycle until i_halt is sampled 1.
  - In the cycle after sampling i_halt: clk_en=0, halted flag set, go to DUMP.
- DUMP:
  - Sequence k=0..31: o_dunit_addr=k, source i_dunit_reg.
  - Then k=0..N_DMEM_WORDS-1: o_dunit_addr=4*k, source i_dunit_mem_data.
  - DUMP_SET drives the address. DUMP_CAP captures the selected input one cycle later (registered-read latency).
  - Each captured word is sent as 4 bytes, MSB first.
  - Per byte: o_tx_start is a one-cycle pulse with o_tx_data stable, then DUMP_WAIT until i_tx_done.
  - o_tx_data holds until the next o_tx_start.
  - After the last byte: o_dunit_addr returns to 0, go to IDLE.
  - Total bytes per dump = 4*(32+N_DMEM_WORDS) = 256 at defaults.
- Simultaneous events:
  - i_rx_done and i_tx_done in the same cycle: i_rx_done is ignored unless in IDLE or LOAD_BYTE.
  - i_halt outside RUN/STEP is ignored.
- o_dunit_w_mem, o_dunit_reset_pc and o_dunit_clk_en are mutually exclusive at all times.

Decomposition:
- Package dunit_pkg holds:
  - command byte constants CMD_LOAD, CMD_RPC, CMD_STEP, CMD_RUN;
  - HALT_WORD 32'h0000003F;
  - the state enumeration localparams;
  - N_GPR = 32.
- One natural sub-module: dunit_word_tx. It is a 32-bit word to 4-byte serialiser with tx_start/tx_done handshake and a done pulse, instantiated once for the DUMP_SEND/DUMP_WAIT path.

Test Plan:
- Reset during DUMP (after 5 bytes sent) -> all outputs 0 next cycle; no further o_tx_start; 'R' accepted afterwards.
- Rx 'L' then bytes 20 28 00 01, 00 00 00 3F -> two w_mem pulses: addr 0 data 0x20280001, then addr 4 data 0x0000003F; state IDLE; subsequent 'X' byte causes no output activity.
- Rx 'R' -> o_dunit_reset_pc high exactly 1 cycle, no clk_en or w_mem.
- Rx 'S' with i_reg returning 0xA0+k for register k -> clk_en high 1 cycle, then 256 o_tx_start pulses (each answered by i_tx_done 3 cycles later); first four bytes 00 00 00 A0, bytes 124..127 00 00 00 BF.
- Rx 'C', assert i_halt on the 9th enabled cycle -> clk_en high exactly 9 cycles, then the dump starts; a following 'S' sends a dump with no clk_en pulse.
- Rx 'S' while a byte is mid-serialisation in DUMP_WAIT -> byte dropped; dump byte count stays 256.

Source files
------------

// File: rtl/dunit_pkg.sv
// Shared definitions for the debug-unit controller.
//   Command bytes received over the UART, the HALT instruction encoding,
//   the controller state enumeration and the GPR count covered by a dump.
package dunit_pkg;

  localparam logic [7:0]  CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0]  CMD_RPC   = 8'h52;  // 'R'
  localparam logic [7:0]  CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0]  CMD_RUN   = 8'h43;  // 'C'

  localparam logic [31:0] HALT_WORD = 32'h0000_003F;
  localparam int          N_GPR     = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_BYTE,
    ST_LOAD_WRITE,
    ST_RPC,
    ST_STEP,
    ST_RUN,
    ST_DUMP_SET,
    ST_DUMP_CAP,
    ST_DUMP_SEND,
    ST_DUMP_WAIT
  } state_t;

endpackage

// File: rtl/dunit_word_tx.sv
// Word-to-bytes serialiser for the dump path.
//   load     : capture word and start sending its MSB byte
//   word     : word to serialise
//   tx_done  : transmitter finished the byte in flight
//   tx_data  : byte to transmit (holds until the next tx_start)
//   tx_start : one-cycle start pulse per byte
//   last     : byte in flight is the final one of the word
//   done     : one-cycle pulse after the final byte completed
module dunit_word_tx #(
  parameter int NB_WORD = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [NB_WORD-1:0] word,
  input  logic               tx_done,
  output logic [NB_BYTE-1:0] tx_data,
  output logic               tx_start,
  output logic               last,
  output logic               done
);

  localparam int N_BYTES = NB_WORD / NB_BYTE;
  localparam int CNT_W   = $clog2(N_BYTES);

  logic [NB_WORD-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  assign last = (cnt == CNT_W'(N_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (load) begin
        tx_data  <= word[NB_WORD-1 -: NB_BYTE];
        shreg    <= word << NB_BYTE;
        cnt      <= '0;
        busy     <= 1'b1;
        tx_start <= 1'b1;
      // a tx_done coinciding with our own start belongs to an older byte
      end else if (busy && tx_done && !tx_start) begin
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          tx_data  <= shreg[NB_WORD-1 -: NB_BYTE];
          shreg    <= shreg << NB_BYTE;
          cnt      <= cnt + CNT_W'(1);
          tx_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Debug-unit controller: decodes UART command bytes into instruction-memory
// writes, PC reset, single-step / continuous clock enables, and serialises a
// register + data-memory dump back to the UART transmitter.
//   i_rx_data/i_rx_done      : received byte stream
//   o_tx_data/o_tx_start     : byte to transmit, start pulse
//   i_tx_done                : transmitter byte complete
//   i_halt                   : pipeline retired HALT
//   o_dunit_clk_en           : pipeline clock enable
//   o_dunit_reset_pc         : PC reset pulse
//   o_dunit_w_mem            : IMEM write strobe
//   o_dunit_addr             : IMEM byte address / dump select
//   o_dunit_data_if          : IMEM write data
//   i_dunit_reg/_mem_data    : registered read data at o_dunit_addr
module debug_unit_ctrl
  import dunit_pkg::*;
#(
  parameter int NB_REG       = 32,
  parameter int NB_BYTE      = 8,
  parameter int NB_ADDR      = 5,
  parameter int N_IMEM_WORDS = 256,
  parameter int N_DMEM_WORDS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic               i_halt,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_reset_pc,
  output logic               o_dunit_w_mem,
  output logic [NB_REG-1:0]  o_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_data_if,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  input  logic [NB_REG-1:0]  i_dunit_mem_data
);

  localparam int BPW    = NB_REG / NB_BYTE;
  localparam int BC_W   = $clog2(BPW);
  localparam int PTR_W  = $clog2(N_IMEM_WORDS);
  localparam int N_DUMP = N_GPR + N_DMEM_WORDS;
  localparam int IDX_W  = $clog2(N_DUMP + 1);

  state_t                    state;
  logic [PTR_W-1:0]          ptr;
  logic [BC_W-1:0]           byte_cnt;
  logic [NB_REG-NB_BYTE-1:0] word_lo;   // first three bytes of the word in progress
  logic                      halted;
  logic [IDX_W-1:0]          idx;       // dump word index: GPRs first, then DMEM

  logic              tx_load, tx_last, tx_word_done;
  logic [NB_REG-1:0] tx_word;

  // dump index -> address: GPR index, then DMEM byte address
  function automatic logic [NB_REG-1:0] dump_addr(input logic [IDX_W-1:0] k);
    if (k < IDX_W'(N_GPR)) return NB_REG'(k[NB_ADDR-1:0]);
    return NB_REG'(k - IDX_W'(N_GPR)) << 2;
  endfunction

  // read data has one cycle of latency after DUMP_SET, so capture in DUMP_CAP
  assign tx_load = (state == ST_DUMP_CAP);
  assign tx_word = (idx < IDX_W'(N_GPR)) ? i_dunit_reg : i_dunit_mem_data;

  dunit_word_tx #(.NB_WORD(NB_REG), .NB_BYTE(NB_BYTE)) u_word_tx (
    .clk      (i_clk),
    .reset    (i_reset),
    .load     (tx_load),
    .word     (tx_word),
    .tx_done  (i_tx_done),
    .tx_data  (o_tx_data),
    .tx_start (o_tx_start),
    .last     (tx_last),
    .done     (tx_word_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= ST_IDLE;
      ptr              <= '0;
      byte_cnt         <= '0;
      word_lo          <= '0;
      halted           <= 1'b0;
      idx              <= '0;
      o_dunit_clk_en   <= 1'b0;
      o_dunit_reset_pc <= 1'b0;
      o_dunit_w_mem    <= 1'b0;
      o_dunit_addr     <= '0;
      o_dunit_data_if  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_rx_done) begin
            case (i_rx_data)
              CMD_LOAD: begin
                halted   <= 1'b0;
                ptr      <= '0;
                byte_cnt <= '0;
                state    <= ST_LOAD_BYTE;
              end
              CMD_RPC: begin
                o_dunit_reset_pc <= 1'b1;
                halted           <= 1'b0;
                state            <= ST_RPC;
              end
              CMD_STEP, CMD_RUN: begin
                if (halted) begin
                  idx          <= '0;
                  o_dunit_addr <= '0;
                  state        <= ST_DUMP_SET;
                end else begin
                  o_dunit_clk_en <= 1'b1;
                  state          <= (i_rx_data == CMD_STEP) ? ST_STEP : ST_RUN;
                end
              end
              default: ;
            endcase
          end
        end

        ST_LOAD_BYTE: begin
          if (i_rx_done) begin
            word_lo  <= {word_lo[NB_REG-2*NB_BYTE-1:0], i_rx_data};
            byte_cnt <= byte_cnt + BC_W'(1);
            if (byte_cnt == BC_W'(BPW - 1)) begin
              o_dunit_w_mem   <= 1'b1;
              o_dunit_addr    <= NB_REG'({ptr, 2'b00});
              o_dunit_data_if <= {word_lo, i_rx_data};
              state           <= ST_LOAD_WRITE;
            end
          end
        end

        ST_LOAD_WRITE: begin
          o_dunit_w_mem <= 1'b0;
          ptr           <= ptr + PTR_W'(1);
          // no wrap: the last IMEM word ends the load even without HALT
          if (o_dunit_data_if == NB_REG'(HALT_WORD) || ptr == PTR_W'(N_IMEM_WORDS - 1))
            state <= ST_IDLE;
          else
            state <= ST_LOAD_BYTE;
        end

        ST_RPC: begin
          o_dunit_reset_pc <= 1'b0;
          state            <= ST_IDLE;
        end

        ST_STEP: begin
          o_dunit_clk_en <= 1'b0;
          if (i_halt) halted <= 1'b1;
          idx          <= '0;
          o_dunit_addr <= '0;
          state        <= ST_DUMP_SET;
        end

        ST_RUN: begin
          if (i_halt) begin
            o_dunit_clk_en <= 1'b0;
            halted         <= 1'b1;
            idx            <= '0;
            o_dunit_addr   <= '0;
            state          <= ST_DUMP_SET;
          end
        end

        ST_DUMP_SET:  state <= ST_DUMP_CAP;
        ST_DUMP_CAP:  state <= ST_DUMP_SEND;
        ST_DUMP_SEND: state <= ST_DUMP_WAIT;

        ST_DUMP_WAIT: begin
          // serialiser launches the next byte on the same edge
          if (i_tx_done && !tx_last) state <= ST_DUMP_SEND;
          if (tx_word_done) begin
            if (idx == IDX_W'(N_DUMP - 1)) begin
              idx          <= '0;
              o_dunit_addr <= '0;
              state        <= ST_IDLE;
            end else begin
              idx          <= idx + IDX_W'(1);
              o_dunit_addr <= dump_addr(idx + IDX_W'(1));
              state        <= ST_DUMP_SET;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Self-checking bench for debug_unit_ctrl: randomized programs, register and
// memory contents and halt points, checked against a dump/write model.
module tb_debug_unit_ctrl;
  import dunit_pkg::*;

  localparam int NB_REG = 32, NB_BYTE = 8, NB_ADDR = 5;
  localparam int N_IMEM_WORDS = 256, N_DMEM_WORDS = 32;
  localparam int DUMP_BYTES = 4 * (N_GPR + N_DMEM_WORDS);

  logic               i_clk = 1'b0, i_reset = 1'b1;
  logic [NB_BYTE-1:0] i_rx_data = '0;
  logic               i_rx_done = 1'b0, i_tx_done = 1'b0, i_halt = 1'b0;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem;
  logic [NB_REG-1:0]  o_dunit_addr, o_dunit_data_if;
  logic [NB_REG-1:0]  i_dunit_reg = '0, i_dunit_mem_data = '0;

  int checks = 0, errors = 0;
  logic [31:0] regs [N_GPR];
  logic [31:0] dmem [N_DMEM_WORDS];
  logic [7:0]  tx_q [$];
  logic [63:0] wr_q [$];
  int en_cycles = 0, rpc_cycles = 0, excl_viol = 0, halt_at = 0, pend = 0;
  bit model_halted = 0;

  debug_unit_ctrl #(.NB_REG(NB_REG), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR),
                    .N_IMEM_WORDS(N_IMEM_WORDS), .N_DMEM_WORDS(N_DMEM_WORDS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .i_halt(i_halt), .o_dunit_clk_en(o_dunit_clk_en), .o_dunit_reset_pc(o_dunit_reset_pc),
    .o_dunit_w_mem(o_dunit_w_mem), .o_dunit_addr(o_dunit_addr),
    .o_dunit_data_if(o_dunit_data_if), .i_dunit_reg(i_dunit_reg),
    .i_dunit_mem_data(i_dunit_mem_data));

  always #5 i_clk = ~i_clk;

  // register file / data memory with one cycle of read latency
  always @(posedge i_clk) begin
    i_dunit_reg      <= regs[o_dunit_addr[NB_ADDR-1:0]];
    i_dunit_mem_data <= dmem[int'(o_dunit_addr >> 2) % N_DMEM_WORDS];
  end

  // monitor, pipeline halt source and UART transmitter (done 3 cycles after start)
  always @(negedge i_clk) begin
    if (o_tx_start) tx_q.push_back(o_tx_data);
    if (o_dunit_w_mem) wr_q.push_back({o_dunit_addr, o_dunit_data_if});
    if (o_dunit_reset_pc) rpc_cycles++;
    if (int'(o_dunit_w_mem) + int'(o_dunit_reset_pc) + int'(o_dunit_clk_en) > 1) excl_viol++;
    i_halt = 1'b0;
    if (o_dunit_clk_en) begin
      en_cycles++;
      if (en_cycles == halt_at) i_halt = 1'b1;
    end
    i_tx_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) i_tx_done = 1'b1;
    end
    if (o_tx_start) pend = 3;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  // cleared mid-cycle so it never races the negedge monitor
  task automatic clear_mon();
    @(posedge i_clk); #2;
    en_cycles = 0; rpc_cycles = 0; halt_at = 0;
    tx_q.delete(); wr_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk); i_rx_data = b; i_rx_done = 1'b1;
    @(negedge i_clk); i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    int c = 0;
    while (tx_q.size() < n && c < 8000) begin @(negedge i_clk); c++; end
    ok = (tx_q.size() >= n);
  endtask

  // expected dump: every GPR then every DMEM word, each MSB byte first
  function automatic int dump_bad();
    int bad = 0;
    logic [31:0] w;
    logic [7:0] e;
    for (int b = 0; b < DUMP_BYTES; b++) begin
      w = (b / 4 < N_GPR) ? regs[b / 4] : dmem[b / 4 - N_GPR];
      e = 8'(w >> (8 * (3 - b % 4)));
      if (b >= tx_q.size() || tx_q[b] !== e) bad++;
    end
    if (tx_q.size() > DUMP_BYTES) bad += tx_q.size() - DUMP_BYTES;
    return bad;
  endfunction

  task automatic fill_mem(input bit a0_regs);
    for (int k = 0; k < N_GPR; k++) regs[k] = a0_regs ? 32'hA0 + 32'(k) : $urandom;
    for (int k = 0; k < N_DMEM_WORDS; k++) dmem[k] = $urandom;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; idle(3);
    checks++;
    if ({o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000",
        {o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem});
    end
    checks++;
    if ({o_tx_data, o_dunit_addr, o_dunit_data_if} !== '0) begin
      errors++; $display("FAIL reset_data: tx=%h addr=%h data=%h expected 0",
        o_tx_data, o_dunit_addr, o_dunit_data_if);
    end
    i_reset = 1'b0; model_halted = 0; idle(2);
  endtask

  task automatic test_load();
    logic [31:0] prog [$];
    logic [31:0] w;
    logic [63:0] e;
    int bad;
    for (int t = 0; t < 3; t++) begin
      prog.delete();
      if (t == 0) begin prog.push_back(32'h2028_0001); prog.push_back(HALT_WORD); end
      else begin
        int n = (t == 1) ? int'($urandom_range(2, 8)) : N_IMEM_WORDS;
        for (int i = 0; i < n; i++) begin
          w = $urandom; if (w == HALT_WORD) w = w + 1; prog.push_back(w);
        end
        if (t == 1) prog.push_back(HALT_WORD);
      end
      clear_mon();
      send_byte(CMD_LOAD);
      foreach (prog[i]) begin
        w = prog[i];
        for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
      end
      idle(5);
      checks++;
      if (wr_q.size() != prog.size()) begin
        errors++; $display("FAIL load%0d_count: got %0d writes expected %0d", t, wr_q.size(), prog.size());
      end
      bad = 0;
      foreach (prog[i]) begin
        e = {32'(4 * i), prog[i]};
        if (i >= wr_q.size() || wr_q[i] !== e) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL load%0d_writes: %0d of %0d writes wrong (addr/data)", t, bad, prog.size());
      end
      // controller must be back in IDLE: junk ignored, then 'R' accepted
      send_byte(8'h58); idle(20);
      checks++;
      if (wr_q.size() != prog.size() || rpc_cycles != 0 || en_cycles != 0 || tx_q.size() != 0) begin
        errors++; $display("FAIL load%0d_junk: writes=%0d rpc=%0d en=%0d tx=%0d expected no activity",
          t, wr_q.size(), rpc_cycles, en_cycles, tx_q.size());
      end
      send_byte(CMD_RPC); idle(4);
      checks++;
      if (rpc_cycles != 1) begin
        errors++; $display("FAIL load%0d_idle: got %0d reset_pc cycles expected 1", t, rpc_cycles);
      end
      model_halted = 0;
    end
  endtask

  task automatic test_rpc();
    clear_mon();
    send_byte(CMD_RPC); idle(6);
    model_halted = 0;
    checks++;
    if (rpc_cycles != 1 || en_cycles != 0 || wr_q.size() != 0) begin
      errors++; $display("FAIL rpc: rpc=%0d en=%0d wr=%0d expected 1/0/0", rpc_cycles, en_cycles, wr_q.size());
    end
  endtask

  // one command producing a dump; halt_pt = enabled cycle on which i_halt rises (0: never)
  task automatic dump_cmd(input string name, input logic [7:0] cmd, input int halt_pt);
    int exp_en, bad;
    bit ok;
    clear_mon();
    halt_at = halt_pt;
    exp_en = model_halted ? 0 : (cmd == CMD_STEP ? 1 : halt_pt);
    if (!model_halted && (cmd == CMD_RUN || halt_pt == 1)) model_halted = 1;
    send_byte(cmd);
    wait_tx(DUMP_BYTES, ok); idle(40);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: got %0d bytes expected %0d", name, tx_q.size(), DUMP_BYTES); end
    checks++;
    if (en_cycles != exp_en) begin errors++; $display("FAIL %s_clk_en: got %0d cycles expected %0d", name, en_cycles, exp_en); end
    bad = dump_bad();
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_dump: %0d bad bytes of %0d (got %0d)", name, bad, DUMP_BYTES, tx_q.size()); end
  endtask

  task automatic test_step();
    fill_mem(1'b1);
    dump_cmd("step", CMD_STEP, 0);
    checks++;
    if (tx_q.size() < 128 || {tx_q[0], tx_q[1], tx_q[2], tx_q[3]} !== 32'h0000_00A0) begin
      errors++; $display("FAIL step_first_word: got %0d bytes expected 000000a0 first", tx_q.size());
    end
    checks++;
    if (tx_q.size() < 128 || {tx_q[124], tx_q[125], tx_q[126], tx_q[127]} !== 32'h0000_00BF) begin
      errors++; $display("FAIL step_reg31: got %0d bytes expected 000000bf at 124..127", tx_q.size());
    end
    fill_mem(1'b0);
    dump_cmd("step_halt", CMD_STEP, 1);
    dump_cmd("step_halted", CMD_STEP, 0);
    test_rpc();
  endtask

  task automatic test_run();
    fill_mem(1'b0);
    dump_cmd("run9", CMD_RUN, 9);
    dump_cmd("run_then_step", CMD_STEP, 0);
    dump_cmd("run_halted", CMD_RUN, 0);
    for (int r = 0; r < 2; r++) begin
      test_rpc();
      fill_mem(1'b0);
      dump_cmd("run_rand", CMD_RUN, int'($urandom_range(1, 30)));
    end
    test_rpc();
  endtask

  task automatic test_rx_during_dump();
    bit ok;
    int bad;
    fill_mem(1'b0);
    clear_mon();
    send_byte(CMD_STEP);
    wait_tx(10, ok);
    // stream commands for a window that spans several tx_done pulses
    for (int i = 0; i < 14; i++) begin
      @(negedge i_clk); i_rx_data = (i % 2 != 0) ? CMD_STEP : CMD_RUN; i_rx_done = 1'b1;
    end
    @(negedge i_clk); i_rx_done = 1'b0;
    wait_tx(DUMP_BYTES, ok); idle(80);
    bad = dump_bad();
    checks++;
    if (bad != 0 || en_cycles != 1) begin
      errors++; $display("FAIL rx_in_dump: bad=%0d bytes=%0d en=%0d expected 0/%0d/1",
        bad, tx_q.size(), en_cycles, DUMP_BYTES);
    end
  endtask

  task automatic test_reset_dump();
    bit ok;
    int n;
    fill_mem(1'b0);
    clear_mon();
    send_byte(CMD_STEP);
    wait_tx(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_dump_start: got %0d bytes expected 5", tx_q.size()); end
    i_reset = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem, o_tx_data, o_dunit_addr, o_dunit_data_if} !== '0) begin
      errors++; $display("FAIL rst_dump_outputs: start=%b tx=%h addr=%h expected all 0",
        o_tx_start, o_tx_data, o_dunit_addr);
    end
    i_reset = 1'b0; model_halted = 0;
    n = tx_q.size();
    idle(80);
    checks++;
    if (tx_q.size() != n) begin errors++; $display("FAIL rst_dump_quiet: got %0d bytes expected %0d", tx_q.size(), n); end
    clear_mon();
    send_byte(CMD_RPC); idle(4);
    checks++;
    if (rpc_cycles != 1) begin errors++; $display("FAIL rst_dump_rpc: got %0d expected 1", rpc_cycles); end
  endtask

  task automatic test_exclusive();
    checks++;
    if (excl_viol != 0) begin errors++; $display("FAIL exclusive: got %0d overlapping cycles expected 0", excl_viol); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_rpc();
    test_step();
    test_run();
    test_rx_during_dump();
    test_reset_dump();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
